// File: rtl/hf_tree_loader_pkg.sv
// Shared definitions for the Huffman tree loader and the downstream decompressor.
// Holds the loader state encoding and the symbol/code/length field widths.
package hf_tree_loader_pkg;

  localparam int unsigned HF_SYM_W      = 4;
  localparam int unsigned HF_CODE_W     = 16;
  localparam int unsigned HF_LEN_W      = 5;
  localparam int unsigned HF_MAX_LEAVES = 16;
  localparam int unsigned HF_IDX_W      = $clog2(HF_MAX_LEAVES);

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StValue,
    StLen,
    StCode,
    StCheck,
    StDone,
    StError
  } hf_state_e;

endpackage

// File: rtl/hf_bit_shifter.sv
// Serial field shifter: shifts bit_i in LSB-first position (MSB of the field arrives first),
// counts shifted bits and flags the cycle on which the last bit of a target-length field
// is being sampled. On that cycle the register and counter clear themselves, so the
// caller must capture next_o (which already includes bit_i) in the same cycle.
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   clear_i       - synchronous clear of data and counter
//   shift_i       - consume bit_i this cycle
//   bit_i         - serial input bit
//   target_i      - field length in bits (must be >= 1 while shifting)
//   next_o        - register contents with bit_i appended
//   done_o        - last bit of the field is being consumed this cycle
module hf_bit_shifter #(
  parameter int unsigned Width = 16,
  parameter int unsigned CntW  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  input  logic [CntW-1:0]  target_i,
  output logic [Width-1:0] next_o,
  output logic             done_o
);

  logic [Width-2:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign next_o = {data_q, bit_i};
  assign done_o = shift_i && (cnt_q == (target_i - CntW'(1)));

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clear_i || done_o) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      data_d = next_o[Width-2:0];
      cnt_d  = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/hf_tree_loader.sv
// Huffman tree-descriptor loader. Parses a serial descriptor (MSB first):
//   4-bit N-1, then per leaf: 4-bit value, 5-bit length L (1..16), L code bits.
// Each parsed leaf is presented with a one-cycle leaf_wr strobe.
// Optional feature: define HF_TREE_CHECKSUM_EN to append a 4-bit checksum field that
// must equal the XOR of all leaf values; a mismatch ends in the error state.
// Ports:
//   CLK, Reset          - clock, asynchronous active-high reset
//   load_start          - start a load (accepted in idle, done or error)
//   hf_in, hf_in_valid  - serial descriptor bit and its qualifier
//   leaf_wr             - leaf write strobe; leaf_idx/code/len/value valid with it
//   building_tree       - load in progress
//   tree_done, tree_err - load finished / descriptor error (levels)
module hf_tree_loader
  import hf_tree_loader_pkg::*;
(
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 load_start,
  input  logic                 hf_in,
  input  logic                 hf_in_valid,
  output logic                 leaf_wr,
  output logic [HF_IDX_W-1:0]  leaf_idx,
  output logic [HF_CODE_W-1:0] leaf_code,
  output logic [HF_LEN_W-1:0]  leaf_len,
  output logic [HF_SYM_W-1:0]  leaf_value,
  output logic                 building_tree,
  output logic                 tree_done,
  output logic                 tree_err
);

  hf_state_e            state_q, state_d;
  logic [HF_IDX_W-1:0]  n_m1_q, n_m1_d;
  logic [HF_SYM_W-1:0]  cur_val_q, cur_val_d;
  logic [HF_LEN_W-1:0]  cur_len_q, cur_len_d;
  logic [HF_IDX_W-1:0]  leaf_idx_q, leaf_idx_d;
  logic [HF_CODE_W-1:0] leaf_code_q, leaf_code_d;
  logic [HF_LEN_W-1:0]  leaf_len_q, leaf_len_d;
  logic [HF_SYM_W-1:0]  leaf_value_q, leaf_value_d;
  logic                 leaf_wr_q, leaf_wr_d;
`ifdef HF_TREE_CHECKSUM_EN
  logic [HF_SYM_W-1:0]  csum_q, csum_d;
`endif

  logic                 sh_clear, sh_shift, sh_done;
  logic [HF_LEN_W-1:0]  sh_target;
  logic [HF_CODE_W-1:0] sh_next;
  logic [HF_LEN_W-1:0]  len_in;

  assign sh_shift = hf_in_valid && (state_q inside {StCount, StValue, StLen, StCode, StCheck});
  assign len_in   = sh_next[HF_LEN_W-1:0];

  always_comb begin
    case (state_q)
      StLen:   sh_target = HF_LEN_W'(HF_LEN_W);
      StCode:  sh_target = cur_len_q;
      default: sh_target = HF_LEN_W'(HF_SYM_W);
    endcase
  end

  hf_bit_shifter #(
    .Width (HF_CODE_W),
    .CntW  (HF_LEN_W)
  ) u_shifter (
    .clk_i    (CLK),
    .rst_i    (Reset),
    .clear_i  (sh_clear),
    .shift_i  (sh_shift),
    .bit_i    (hf_in),
    .target_i (sh_target),
    .next_o   (sh_next),
    .done_o   (sh_done)
  );

  always_comb begin
    state_d      = state_q;
    n_m1_d       = n_m1_q;
    cur_val_d    = cur_val_q;
    cur_len_d    = cur_len_q;
    leaf_idx_d   = leaf_idx_q;
    leaf_code_d  = leaf_code_q;
    leaf_len_d   = leaf_len_q;
    leaf_value_d = leaf_value_q;
    leaf_wr_d    = 1'b0;
    sh_clear     = 1'b0;
`ifdef HF_TREE_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    // leaf_idx holds through the strobe cycle and advances as the strobe ends.
    if (leaf_wr_q && (leaf_idx_q != n_m1_q)) begin
      leaf_idx_d = leaf_idx_q + HF_IDX_W'(1);
    end
    case (state_q)
      StIdle, StDone, StError: begin
        if (load_start) begin
          state_d    = StCount;
          sh_clear   = 1'b1;
          leaf_idx_d = '0;
`ifdef HF_TREE_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      StCount: begin
        if (sh_done) begin
          n_m1_d  = sh_next[HF_IDX_W-1:0];
          state_d = StValue;
        end
      end
      StValue: begin
        if (sh_done) begin
          cur_val_d = sh_next[HF_SYM_W-1:0];
          state_d   = StLen;
        end
      end
      StLen: begin
        if (sh_done) begin
          if ((len_in == '0) || (len_in > HF_LEN_W'(HF_CODE_W))) begin
            state_d = StError;
          end else begin
            cur_len_d = len_in;
            state_d   = StCode;
          end
        end
      end
      StCode: begin
        if (sh_done) begin
          leaf_wr_d    = 1'b1;
          leaf_code_d  = sh_next;
          leaf_len_d   = cur_len_q;
          leaf_value_d = cur_val_q;
`ifdef HF_TREE_CHECKSUM_EN
          csum_d       = csum_q ^ cur_val_q;
          state_d      = (leaf_idx_q == n_m1_q) ? StCheck : StValue;
`else
          state_d      = (leaf_idx_q == n_m1_q) ? StDone : StValue;
`endif
        end
      end
`ifdef HF_TREE_CHECKSUM_EN
      StCheck: begin
        if (sh_done) begin
          state_d = (sh_next[HF_SYM_W-1:0] == csum_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      n_m1_q       <= '0;
      cur_val_q    <= '0;
      cur_len_q    <= '0;
      leaf_idx_q   <= '0;
      leaf_code_q  <= '0;
      leaf_len_q   <= '0;
      leaf_value_q <= '0;
      leaf_wr_q    <= 1'b0;
`ifdef HF_TREE_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      n_m1_q       <= n_m1_d;
      cur_val_q    <= cur_val_d;
      cur_len_q    <= cur_len_d;
      leaf_idx_q   <= leaf_idx_d;
      leaf_code_q  <= leaf_code_d;
      leaf_len_q   <= leaf_len_d;
      leaf_value_q <= leaf_value_d;
      leaf_wr_q    <= leaf_wr_d;
`ifdef HF_TREE_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign leaf_wr       = leaf_wr_q;
  assign leaf_idx      = leaf_idx_q;
  assign leaf_code     = leaf_code_q;
  assign leaf_len      = leaf_len_q;
  assign leaf_value    = leaf_value_q;
  assign building_tree = state_q inside {StCount, StValue, StLen, StCode, StCheck};
  assign tree_done     = (state_q == StDone);
  assign tree_err      = (state_q == StError);

endmodule

// File: doc/hf_tree_loader.md
HF_TREE_LOADER -- requirements
Module: hf_tree_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 load_start  input  1  single-cycle pulse requesting a tree-descriptor load.
REQ-005 hf_in  input  1  serial descriptor bit.
REQ-006 hf_in_valid  input  1  hf_in qualifier; a bit is consumed only on cycles where this is 1.
REQ-007 leaf_wr  output  1  single-cycle leaf write strobe.
REQ-008 leaf_idx  output  4  leaf slot being written, 0 = leaf A through 15 = leaf P.
REQ-009 leaf_code  output  16  received code, right-aligned and zero-extended.
REQ-010 leaf_len  output  5  code length, 1..16.
REQ-011 leaf_value  output  4  decoded symbol for the leaf.
REQ-012 building_tree  output  1  1 from load_start acceptance until DONE or ERROR.
REQ-013 tree_done  output  1  level; tree loaded and valid.
REQ-014 tree_err  output  1  level; sticky descriptor error.

Function
REQ-015 Descriptor format, MSB first, SHALL be: 4-bit N-1 (N = 1..16 leaves); then per leaf: 4-bit value, 5-bit length L, then L code bits.
REQ-016 States SHALL be IDLE, COUNT, VALUE, LEN, CODE, CHECK (macro only), DONE, ERROR.
REQ-017 IDLE->COUNT on load_start; building_tree goes to 1 in the same edge.
REQ-018 COUNT, VALUE and LEN SHALL each shift in exactly 4, 4 and 5 valid bits respectively, counted by a 5-bit bit counter, then advance.
REQ-019 LEN with L=0 or L>16 SHALL go to ERROR on the edge that samples the last length bit.
REQ-020 CODE SHALL shift L valid bits into a 16-bit register as {code[14:0], hf_in}, cleared at VALUE entry.
REQ-021 leaf_wr SHALL pulse for exactly one cycle, on the cycle after the last code bit is sampled, with leaf_idx/code/len/value stable during that cycle.
REQ-022 After a leaf write, the FSM SHALL go to VALUE with leaf_idx+1 if leaf_idx < N-1; otherwise it goes to CHECK or DONE.
REQ-023 Cycles with hf_in_valid=0 SHALL hold all state, counters and outputs, except that the leaf_wr pulse still deasserts.
REQ-024 DONE SHALL set tree_done=1 and building_tree=0; ERROR SHALL set tree_err=1 and building_tree=0.
REQ-025 load_start in DONE or ERROR SHALL restart at COUNT, clearing tree_done, tree_err and leaf_idx.
REQ-026 load_start in COUNT..CHECK SHALL be ignored.
REQ-027 Bits presented in IDLE, DONE or ERROR SHALL be discarded.
REQ-028 No duplicate-code or prefix checking is performed; the downstream decoder's first-match priority (lowest leaf_idx) resolves conflicts.

Reset
REQ-029 Reset SHALL force IDLE, with all counters, the code register and all outputs at 0.
REQ-030 Reset mid-load SHALL abort the load with no further leaf_wr; the partially loaded table is not invalidated by this block.

Configuration
REQ-031 With HF_TREE_CHECKSUM_EN defined, CHECK SHALL consume 4 valid bits and compare them to the XOR of all leaf values: on a match the FSM goes to DONE, otherwise to ERROR.
REQ-032 Without HF_TREE_CHECKSUM_EN, the CHECK state and its logic SHALL be absent and the last leaf goes directly to DONE.

Structure
REQ-033 A shared package SHALL hold the state encoding, HF_SYM_W=4, HF_CODE_W=16, HF_LEN_W=5 and HF_MAX_LEAVES=16, reused by the decompressor.
REQ-034 One sub-module, hf_bit_shifter (a parameterised width shift register with a bit counter and a done flag), SHALL be instantiated once and reused per field.

Verification
REQ-035 Reset, then load_start with N-1=0001, leaf0 v=3 L=1 code 0, leaf1 v=9 L=1 code 1 -> leaf_wr idx0 code 0x0000 len 1 val 3, then idx1 code 0x0001 len 1 val 9, then tree_done=1.
REQ-036 Same stream with hf_in_valid toggling 1,0,1,0 -> identical leaf writes, each delayed, with no extra or lost bits.
REQ-037 Length field 00000 -> tree_err=1 with no leaf_wr for that leaf; then load_start -> tree_err=0 and building_tree=1.
REQ-038 16 leaves, each L=16 with code 0xFFFF-idx -> 16 leaf_wr pulses, the last with code 0xFFF0, then tree_done.
REQ-039 Reset asserted after 2 code bits of leaf 0 -> all outputs 0 and no leaf_wr follows.
REQ-040 With HF_TREE_CHECKSUM_EN and values 3,9 -> checksum 1010 gives tree_done; checksum 0000 gives tree_err.
